uart_tx_feeder: RTL and testbench

Byte-buffering front end for the UART transmitter, clocked by `txclk`. It accepts bytes from a host-side write port into an internal FIFO. It hands them one at a time to the UART transmit interface (`ld_tx_data` / `tx_data`), pacing loads on the UART's `tx_empty` status so a byte is never loaded into a busy transmitter. It sits directly upstream of the `uart` transmit side and replaces ad-hoc testbench driving of `ld_tx_data`.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync_fifo.sv | 68 ++++++
 rtl/uart_tx_feeder.sv | 80 ++++++++
 tb/tb_uart_tx_feeder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: byte type, transmit-feeder launch states and default FIFO depth.
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        GUARD,
        BUSY
    } tx_feed_state_e;

    localparam int UART_TX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular-buffer FIFO with registered full/empty/level flags and a
// one-cycle overflow pulse for dropped writes. Shared by the UART TX and RX sides.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_TX_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    uart_byte_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          wr_ok;
    logic          rd_ok;

    // A write while full is dropped even if a pop frees a slot this same cycle.
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    always_comb begin
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            full     <= (count_nxt == FULL_CNT);
            empty    <= (count_nxt == '0);
            overflow <= wr_en && full;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and launches them into the UART transmitter one frame at a time,
// only when the transmitter reports idle.
//
//   state | meaning
//   IDLE  | waiting for tx_go, a buffered byte and an idle transmitter
//   LOAD  | ld_tx_data high for this single cycle, tx_data valid
//   GUARD | tx_empty ignored while the UART registers the load
//   BUSY  | frame in flight, waiting for tx_empty
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_TX_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          txclk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          tx_go,
    output logic          full,
    output logic          fifo_empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          ld_tx_data,
    output logic [7:0]    tx_data,
    input  logic          tx_empty
);

    tx_feed_state_e state;
    tx_feed_state_e state_nxt;
    logic           launch;
    uart_byte_t     rd_data;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk      (txclk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (launch),
        .rd_data  (rd_data),
        .full     (full),
        .empty    (fifo_empty),
        .level    (level),
        .overflow (overflow)
    );

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (tx_go && !fifo_empty && tx_empty) begin
                    state_nxt = LOAD;
                    launch    = 1'b1;
                end
            end
            LOAD:    state_nxt = GUARD;
            GUARD:   state_nxt = BUSY;
            BUSY:    if (tx_empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Load strobe comes straight from a flop so the UART never sees a decode glitch.
    always_ff @(posedge txclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ld_tx_data <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            state      <= state_nxt;
            ld_tx_data <= (state_nxt == LOAD);
            if (launch) tx_data <= rd_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a behavioural UART transmitter model.
module tb_uart_tx_feeder;

    localparam int FRAME = 10;

    logic       txclk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_go = 1'b1;
    logic       full;
    logic       fifo_empty;
    logic [4:0] level;
    logic       overflow;
    logic       ld_tx_data;
    logic [7:0] tx_data;
    logic       tx_empty;

    int n_cmp = 0;
    int n_err = 0;
    int bad_loads = 0;
    logic [7:0] got[$];
    logic [7:0] exp[$];
    int         uart_cnt;
    logic       prev_ld;

    uart_tx_feeder dut (
        .txclk      (txclk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .tx_go      (tx_go),
        .full       (full),
        .fifo_empty (fifo_empty),
        .level      (level),
        .overflow   (overflow),
        .ld_tx_data (ld_tx_data),
        .tx_data    (tx_data),
        .tx_empty   (tx_empty)
    );

    always #5 txclk = ~txclk;

    // UART transmitter model: busy for FRAME cycles after it samples a load.
    always @(posedge txclk or posedge reset) begin
        if (reset) begin
            tx_empty <= 1'b1;
            uart_cnt <= 0;
        end else if (ld_tx_data && tx_empty) begin
            tx_empty <= 1'b0;
            uart_cnt <= FRAME;
        end else if (!tx_empty) begin
            if (uart_cnt == 1) tx_empty <= 1'b1;
            uart_cnt <= uart_cnt - 1;
        end
    end

    // Records every load the UART samples and flags illegal ones.
    always @(posedge txclk or posedge reset) begin
        if (reset) begin
            prev_ld <= 1'b0;
        end else begin
            prev_ld <= ld_tx_data;
            if (ld_tx_data) begin
                if (!tx_empty || prev_ld) bad_loads = bad_loads + 1;
                got.push_back(tx_data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_write(input logic [7:0] b);
        @(negedge txclk);
        wr_en   = 1'b1;
        wr_data = b;
        exp.push_back(b);
    endtask

    task automatic end_write();
        @(negedge txclk);
        wr_en = 1'b0;
    endtask

    task automatic wait_loads(input int n, input int budget);
        int c = 0;
        while (got.size() < n && c < budget) begin
            @(negedge txclk);
            c++;
        end
        chk("wait_loads", 32'(got.size()), 32'(n));
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) chk(tag, 32'(got[i]), 32'(exp[i]));
        end
        got.delete();
        exp.delete();
    endtask

    initial begin
        repeat (3) @(negedge txclk);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_fifo_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_ld", 32'(ld_tx_data), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        reset = 1'b0;

        // Single byte: load one cycle after the write edge.
        push_write(8'hA5);
        end_write();
        chk("single_level1", 32'(level), 32'd1);
        chk("single_not_empty", 32'(fifo_empty), 32'd0);
        chk("single_no_ld_yet", 32'(ld_tx_data), 32'd0);
        @(negedge txclk);
        chk("single_ld", 32'(ld_tx_data), 32'd1);
        chk("single_tx_data", 32'(tx_data), 32'hA5);
        chk("single_level0", 32'(level), 32'd0);
        @(negedge txclk);
        chk("single_ld_one_cycle", 32'(ld_tx_data), 32'd0);
        chk("single_tx_data_hold", 32'(tx_data), 32'hA5);
        wait_loads(1, 40);
        repeat (FRAME + 8) @(negedge txclk);
        cmp_stream("single");

        // Burst of five back-to-back bytes.
        for (int i = 1; i <= 5; i++) push_write(8'(i));
        end_write();
        wait_loads(5, 5 * (FRAME + 6) + 20);
        repeat (FRAME + 8) @(negedge txclk);
        cmp_stream("burst");
        chk("burst_empty", 32'(fifo_empty), 32'd1);

        // Fill with launching disabled; the 17th write is dropped.
        tx_go = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge txclk);
            wr_en   = 1'b1;
            wr_data = 8'(8'hB0 + i);
            if (i < 16) exp.push_back(8'(8'hB0 + i));
            @(posedge txclk);
            #1;
            if (i == 15) begin
                chk("fill_full", 32'(full), 32'd1);
                chk("fill_level16", 32'(level), 32'd16);
                chk("fill_no_ovf", 32'(overflow), 32'd0);
            end
            if (i == 16) begin
                chk("ovf_pulse", 32'(overflow), 32'd1);
                chk("ovf_level16", 32'(level), 32'd16);
            end
        end
        @(negedge txclk);
        wr_en = 1'b0;
        @(posedge txclk);
        #1;
        chk("ovf_one_cycle", 32'(overflow), 32'd0);
        chk("no_load_tx_go0", 32'(got.size()), 32'd0);
        tx_go = 1'b1;
        wait_loads(16, 16 * (FRAME + 6) + 20);
        repeat (FRAME + 8) @(negedge txclk);
        cmp_stream("drain");
        chk("drain_empty", 32'(fifo_empty), 32'd1);
        chk("drain_not_full", 32'(full), 32'd0);

        // Forty writes in rounds while draining, wrapping the pointers.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 10; i++) push_write(8'((r * 10 + i) * 7 + 3));
            end_write();
            wait_loads((r + 1) * 10, 10 * (FRAME + 6) + 40);
        end
        repeat (FRAME + 8) @(negedge txclk);
        cmp_stream("wrap");
        chk("wrap_level0", 32'(level), 32'd0);

        // Drop tx_go while the first frame is in flight.
        push_write(8'hC1);
        push_write(8'hC2);
        end_write();
        wait_loads(1, 40);
        repeat (3) @(negedge txclk);
        tx_go = 1'b0;
        repeat (FRAME + 20) @(negedge txclk);
        chk("go_low_loads", 32'(got.size()), 32'd1);
        chk("go_low_level", 32'(level), 32'd1);

        // Reset asynchronously while the next frame is in flight.
        tx_go = 1'b1;
        push_write(8'hC3);
        push_write(8'hC4);
        end_write();
        wait_loads(2, FRAME + 40);
        repeat (3) @(negedge txclk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_empty", 32'(fifo_empty), 32'd1);
        chk("mid_rst_ld", 32'(ld_tx_data), 32'd0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'h00);
        @(negedge txclk);
        reset = 1'b0;
        repeat (FRAME + 20) @(negedge txclk);
        chk("post_rst_loads", 32'(got.size()), 32'd2);
        chk("post_rst_level", 32'(level), 32'd0);
        if (got.size() >= 2) begin
            chk("go_rst_byte0", 32'(got[0]), 32'hC1);
            chk("go_rst_byte1", 32'(got[1]), 32'hC2);
        end
        chk("bad_loads", 32'(bad_loads), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
